// File: rtl/sample_fifo_pkg.sv
// Shared types for the sample FIFO: occupancy update decision.
package sample_fifo_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  function automatic cnt_op_e cnt_op(input logic wr_acc, input logic rd_acc);
    if (wr_acc && !rd_acc) return CNT_INC;
    if (rd_acc && !wr_acc) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/sample_fifo_sdp_ram_sync.sv
// Simple dual-port RAM, single clock, registered read port that updates only on re.
module sdp_ram_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= din;
    if (re) r_dout <= r_mem[raddr];
  end

  assign dout = r_dout;

endmodule

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO over a registered-read block RAM: pointers, occupancy,
// registered status flags, sticky error flags and synchronous flush.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 9,
  parameter int unsigned ALMOST_FULL_TH  = 480,
  parameter int unsigned ALMOST_EMPTY_TH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, r_count;
  logic                  r_full, r_empty, r_afull, r_aempty;
  logic                  r_ovf, r_unf, r_dout_valid, r_dout_zero;
  logic                  w_flush, w_wr_acc, w_rd_acc, w_ram_we, w_ram_re;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [DATA_WIDTH-1:0] w_ram_dout;

  assign w_flush  = rst | clear;
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;
  assign w_ram_we = w_wr_acc & ~w_flush;
  assign w_ram_re = w_rd_acc & ~w_flush;

  always_comb begin
    w_count_nxt = r_count;
    unique case (cnt_op(w_wr_acc, w_rd_acc))
      CNT_INC:  w_count_nxt = r_count + 1'b1;
      CNT_DEC:  w_count_nxt = r_count - 1'b1;
      default:  w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_aempty     <= 1'b1;
      r_afull      <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_dout_valid <= 1'b0;
      if (rst) r_dout_zero <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count      <= w_count_nxt;
      r_empty      <= (w_count_nxt == '0);
      r_full       <= (w_count_nxt == DEPTH_C);
      r_aempty     <= (w_count_nxt <= AE_TH);
      r_afull      <= (w_count_nxt >= AF_TH);
      r_ovf        <= r_ovf | (wr_en & r_full);
      r_unf        <= r_unf | (rd_en & r_empty);
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) r_dout_zero <= 1'b0;
    end
  end

  sdp_ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .din   (din),
    .re    (w_ram_re),
    .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .dout  (w_ram_dout)
  );

  // RAM output register has no reset; mask it to zero until the first read after rst.
  assign dout         = r_dout_zero ? '0 : w_ram_dout;
  assign dout_valid   = r_dout_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo at default parameters.
module tb_sample_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        dout_valid, full, empty, almost_full, almost_empty;
  logic [9:0]  count;
  logic        overflow, underflow;

  int errors = 0;
  int checks = 0;

  sample_fifo #(
    .DATA_WIDTH      (8),
    .ADDR_WIDTH      (9),
    .ALMOST_FULL_TH  (480),
    .ALMOST_EMPTY_TH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 10'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", dout_valid); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b%b exp=00", overflow, underflow); end
    checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", almost_empty, almost_full); end
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 5; i++) begin
      din = 8'(i); wr_en = 1'b1;
      tick();
      checks++; if (empty !== 1'b0 || count !== 10'(i)) begin errors++; $display("FAIL basic_wr%0d got count=%0d empty=%b exp count=%0d empty=0", i, count, empty, i); end
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (dout !== 8'(i) || dout_valid !== 1'b1) begin errors++; $display("FAIL basic_rd%0d got dout=%h dv=%b exp dout=%h dv=1", i, dout, dout_valid, 8'(i)); end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (empty !== 1'b1 || count !== 10'd0) begin errors++; $display("FAIL basic_empty got empty=%b count=%0d exp 1/0", empty, count); end
    checks++; if (dout_valid !== 1'b0 || dout !== 8'h05) begin errors++; $display("FAIL basic_hold got dout=%h dv=%b exp 05/0", dout, dout_valid); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 512; i++) begin
      din = 8'(i); wr_en = 1'b1;
      tick();
      if (i + 1 == 479) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_af479 got=%b exp=0", almost_full); end
      end
      if (i + 1 == 480) begin
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af480 got=%b exp=1", almost_full); end
      end
      if (i + 1 == 511) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full511 got=%b exp=0", full); end
      end
    end
    checks++; if (full !== 1'b1 || count !== 10'd512) begin errors++; $display("FAIL fill_full got full=%b count=%0d exp 1/512", full, count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_noovf got=%b exp=0", overflow); end
    din = 8'hAA;
    tick();
    checks++; if (overflow !== 1'b1 || count !== 10'd512) begin errors++; $display("FAIL fill_ovf got ovf=%b count=%0d exp 1/512", overflow, count); end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b1) begin errors++; $display("FAIL fill_rd0 got dout=%h dv=%b exp 00/1", dout, dout_valid); end
    checks++; if (full !== 1'b0 || count !== 10'd511) begin errors++; $display("FAIL fill_unfull got full=%b count=%0d exp 0/511", full, count); end
    rd_en = 1'b0; wr_en = 1'b1; din = 8'hAA;
    tick();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_refull got=%b exp=1", full); end
    rd_en = 1'b1; din = 8'hBB;
    tick();
    checks++; if (count !== 10'd511 || overflow !== 1'b1) begin errors++; $display("FAIL fill_wrrd_full got count=%0d ovf=%b exp 511/1", count, overflow); end
    checks++; if (dout !== 8'h01 || dout_valid !== 1'b1) begin errors++; $display("FAIL fill_wrrd_data got dout=%h dv=%b exp 01/1", dout, dout_valid); end
    wr_en = 1'b0; rd_en = 1'b0;
    do_clear();
    checks++; if (count !== 10'd0 || overflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fill_clear got count=%0d ovf=%b empty=%b exp 0/0/1", count, overflow, empty); end
  endtask

  task automatic test_back_to_back;
    for (int v = 0; v < 10; v++) begin
      din = 8'(v * 7 + 3); wr_en = 1'b1;
      tick();
    end
    checks++; if (count !== 10'd10) begin errors++; $display("FAIL b2b_pre got count=%0d exp 10", count); end
    rd_en = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      din = 8'((j + 10) * 7 + 3);
      tick();
      checks++; if (dout !== 8'(j * 7 + 3) || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_data%0d got dout=%h dv=%b exp %h/1", j, dout, dout_valid, 8'(j * 7 + 3)); end
      checks++; if (count !== 10'd10) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=10", j, count); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL b2b_sticky got ovf=%b unf=%b exp 0/0", overflow, underflow); end
    do_clear();
  endtask

  task automatic test_errors;
    rd_en = 1'b1;
    tick();
    checks++; if (underflow !== 1'b1 || count !== 10'd0) begin errors++; $display("FAIL err_rd_empty got unf=%b count=%0d exp 1/0", underflow, count); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL err_rd_empty_dv got=%b exp=0", dout_valid); end
    do_clear();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL err_clear_unf got=%b exp=0", underflow); end
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h5A;
    tick();
    checks++; if (underflow !== 1'b1 || count !== 10'd1 || empty !== 1'b0) begin errors++; $display("FAIL err_wrrd_empty got unf=%b count=%0d empty=%b exp 1/1/0", underflow, count, empty); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL err_wrrd_empty_dv got=%b exp=0", dout_valid); end
    wr_en = 1'b0;
    tick();
    checks++; if (dout !== 8'h5A || dout_valid !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL err_rd_after got dout=%h dv=%b unf=%b exp 5a/1/1", dout, dout_valid, underflow); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_clear;
    for (int i = 0; i < 101; i++) begin
      din = 8'(i + 1); wr_en = 1'b1;
      tick();
      if (i + 1 == 32) begin
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL clr_ae32 got=%b exp=1", almost_empty); end
      end
      if (i + 1 == 33) begin
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL clr_ae33 got=%b exp=0", almost_empty); end
      end
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    checks++; if (dout !== 8'h01 || dout_valid !== 1'b1 || count !== 10'd100) begin errors++; $display("FAIL clr_pre got dout=%h dv=%b count=%0d exp 01/1/100", dout, dout_valid, count); end
    clear = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
    tick();
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 10'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL clr_state got count=%0d empty=%b ae=%b exp 0/1/1", count, empty, almost_empty); end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL clr_sticky got ovf=%b unf=%b exp 0/0", overflow, underflow); end
    checks++; if (dout !== 8'h01 || dout_valid !== 1'b0) begin errors++; $display("FAIL clr_dout got dout=%h dv=%b exp 01/0", dout, dout_valid); end
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (underflow !== 1'b1 || dout_valid !== 1'b0 || count !== 10'd0) begin errors++; $display("FAIL clr_nowrite got unf=%b dv=%b count=%0d exp 1/0/0", underflow, dout_valid, count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_errors();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_fifo.md
Name: sample_fifo

Overview:
- Parametrised single-clock synchronous FIFO for buffering ADC/sample data between capture and readout logic.
- Built on a simple dual-port block RAM with a registered read port.
- Adds what a bare RAM lacks: pointer management, occupancy count, full/empty/almost flags, sticky overflow/underflow error flags, and a synchronous flush.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- ADDR_WIDTH, 9, log2 of depth; DEPTH = 2^ADDR_WIDTH (512 by default); all DEPTH entries are usable.
- ALMOST_FULL_TH, 480, almost_full asserted when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 32, almost_empty asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as rst on all state except dout.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data, registered.
- dout_valid  out  1  dout carries a newly read word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_TH.
- almost_empty  out  1  count <= ALMOST_EMPTY_TH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected because the FIFO was full.
- underflow  out  1  sticky: a read was rejected because the FIFO was empty.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0 (the ALMOST_FULL_TH >= 1 constraint guarantees this).
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - RAM contents are not reset.
- Pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the RAM; they wrap naturally modulo 2*DEPTH.
- Acceptance is evaluated against the registered flags in the current cycle:
  - Write accepted iff wr_en && !full: RAM[wr_ptr] <= din, wr_ptr += 1.
  - Read accepted iff rd_en && !empty: rd_ptr += 1.
- Read latency is 1 cycle. The word appears on dout the cycle after acceptance, with dout_valid=1 for exactly that cycle. dout holds its last value when dout_valid=0.
- No fall-through: a word written in cycle N is readable from cycle N+1 (empty deasserts at N+1). rd_en in cycle N while empty is rejected.
- count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged on simultaneous accept or when nothing is accepted.
- Flags are registered and derived from next-count, so they are valid in the same cycle as count.
- Simultaneous wr_en && rd_en:
  - Full: read accepted, write rejected, overflow set, count goes to DEPTH-1.
  - Empty: write accepted, read rejected, underflow set, count goes to 1.
  - Otherwise: both accepted, count unchanged.
- Sticky flags:
  - overflow is set on any rejected write; underflow is set on any rejected read.
  - Both stay set until rst or clear.
- clear has priority over wr_en/rd_en in the same cycle. It does everything rst does except that dout holds its value. A read accepted the cycle before clear still produces its dout_valid pulse.
- rst has priority over clear.
- Mid-operation rst/clear: in-flight data is discarded; no dout_valid is produced after the rst edge.
- RAM is inferred from a sub-module with the read-during-write-same-address result unused. Any address collision can only occur when count is 0 or DEPTH, and in those cases one side is always rejected.

Decomposition:
- No shared package is required.
- DEPTH = 1<<ADDR_WIDTH is a localparam.
- Flag thresholds are module parameters.
- Sub-module sdp_ram_sync:
  - Simple dual-port RAM on a single clk.
  - Ports: we, waddr, din, re, raddr, dout.
  - Registered dout, updated only when re=1.
  - Parametrised by DATA_WIDTH and ADDR_WIDTH.
- sample_fifo holds pointers, count, flags and dout_valid.

Test Plan:
- Reset then idle 5 cycles -> empty=1, count=0, dout=0, dout_valid=0, overflow=underflow=0.
- Write 0x01..0x05 in 5 cycles, then read 5 -> dout sequence 0x01..0x05, each one cycle after rd_en with dout_valid=1; empty=1 after the last read.
- Fill 512 words (0x00..0xFF repeating) then one extra write -> full=1 at count=512, almost_full=1 from count 480, overflow=1; a read then returns 0x00 and full deasserts.
- wr_en=rd_en=1 continuously for 1000 cycles starting with count=10 -> count stays 10, data order preserved across pointer wrap, no error flags.
- Read on empty, and wr_en&rd_en on empty -> underflow=1, count=1, no dout_valid; wr&rd on full -> count=511, overflow=1.
- clear asserted with count=100 together with wr_en/rd_en -> next cycle count=0, empty=1, flags cleared, dout unchanged, write not stored.
